// File: rtl/tug_engine.sv
// Game core for the two-player ADC tug-of-war display: single-player bar level with
// hysteresis, or a rate-limited tug-of-war match, decoded onto the renderer's screen index.
module tug_engine #(
    parameter int DATA_W      = 12,
    parameter int NPOS        = 15,
    parameter int STEP_CYCLES = 1000000,
    parameter int DEADBAND    = 64,
    parameter int HYST        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              start,
    input  logic [DATA_W-1:0] p1data,
    input  logic [DATA_W-1:0] p2data,
    output logic [5:0]        screen,
    output logic [3:0]        level,
    output logic [3:0]        pos,
    output logic              running,
    output logic              p1_win,
    output logic              p2_win,
    output logic              step
);

    localparam int SH = DATA_W - 4;
    localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_CYCLES - 1);
    localparam logic [3:0] CENTER = 4'((NPOS - 1) / 2);
    localparam logic [3:0] LAST = 4'(NPOS - 1);
    localparam logic [SH:0] HYST_V = (SH+1)'(HYST);
    localparam logic [SH:0] BIN_SPAN = (SH+1)'(1 << SH);
    localparam logic signed [DATA_W:0] DB_POS = (DATA_W+1)'(DEADBAND);
    localparam logic signed [DATA_W:0] DB_NEG = -DB_POS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] p1_q, p2_q;
    logic              mode_q;
    logic [CW-1:0]     cnt, cnt_n;
    logic [3:0]        pos_n, level_n, pos_mv;
    logic              p1_win_n, p2_win_n;
    logic              mode_chg, start_m;
    logic [3:0]        bin;
    logic [SH-1:0]     low;
    logic [SH:0]       up_gap, down_gap;
    logic signed [DATA_W:0] diff;

    assign mode_chg = (mode != mode_q);
    // A mode edge outranks a simultaneous start; start means nothing in single mode.
    assign start_m  = mode & start & ~mode_chg;
    assign step     = (cnt == CNT_MAX);
    assign running  = (state == RUN);

    assign bin      = p1_q[DATA_W-1 -: 4];
    assign low      = p1_q[SH-1:0];
    assign up_gap   = {1'b0, low};
    assign down_gap = BIN_SPAN - {1'b0, low};
    assign diff     = $signed({1'b0, p1_q}) - $signed({1'b0, p2_q});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q   <= '0;
            p2_q   <= '0;
            mode_q <= 1'b0;
            cnt    <= '0;
        end else begin
            p1_q   <= p1data;
            p2_q   <= p2data;
            mode_q <= mode;
            cnt    <= cnt_n;
        end
    end

    always_comb begin
        cnt_n = step ? '0 : cnt + CW'(1);
        if (mode_chg || start_m)
            cnt_n = '0;
        else if (mode && (state != RUN))
            cnt_n = '0;
    end

    always_comb begin
        level_n = level;
        if (!mode && step && !mode_chg) begin
            if ((bin > level) && (up_gap >= HYST_V))
                level_n = bin;
            else if ((bin < level) && (down_gap > HYST_V))
                level_n = bin;
        end
    end

    always_comb begin
        pos_mv = pos;
        if (diff > DB_POS)
            pos_mv = (pos == LAST) ? pos : pos + 4'd1;
        else if (diff < DB_NEG)
            pos_mv = (pos == 4'd0) ? pos : pos - 4'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pos    <= CENTER;
            level  <= 4'd0;
            p1_win <= 1'b0;
            p2_win <= 1'b0;
        end else begin
            state  <= state_n;
            pos    <= pos_n;
            level  <= level_n;
            p1_win <= p1_win_n;
            p2_win <= p2_win_n;
        end
    end

    always_comb begin
        state_n  = state;
        pos_n    = pos;
        p1_win_n = p1_win;
        p2_win_n = p2_win;
        if (mode_chg || !mode) begin
            state_n = IDLE;
            if (mode_chg) begin
                pos_n    = CENTER;
                p1_win_n = 1'b0;
                p2_win_n = 1'b0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_m) begin
                        state_n  = RUN;
                        pos_n    = CENTER;
                        p1_win_n = 1'b0;
                        p2_win_n = 1'b0;
                    end
                end
                RUN: begin
                    // Restart discards any step landing in the same cycle.
                    if (start_m) begin
                        pos_n = CENTER;
                    end else if (step) begin
                        pos_n = pos_mv;
                        if (pos_mv == LAST) begin
                            state_n  = WIN;
                            p1_win_n = 1'b1;
                        end else if (pos_mv == 4'd0) begin
                            state_n  = WIN;
                            p2_win_n = 1'b1;
                        end
                    end
                end
                WIN: begin
                    if (start_m) begin
                        state_n  = RUN;
                        pos_n    = CENTER;
                        p1_win_n = 1'b0;
                        p2_win_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        screen = 6'd31;
        if (!mode)
            screen = {2'b00, level};
        else if (state != IDLE)
            screen = 6'd16 + {2'b00, pos};
    end

endmodule

// File: tb/tb_tug_engine.sv
// Randomised bench for tug_engine: a driver pushes expected post-step snapshots from an
// abstract game model; a monitor pops one at every step strobe and compares.
module tb_tug_engine;

    localparam int DATA_W      = 12;
    localparam int NPOS        = 15;
    localparam int STEP_CYCLES = 4;
    localparam int DEADBAND    = 64;
    localparam int HYST        = 16;
    localparam int SH          = DATA_W - 4;
    localparam int CENTER      = (NPOS - 1) / 2;
    localparam int MAXV        = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              mode = 1'b0;
    logic              start = 1'b0;
    logic [DATA_W-1:0] p1data = '0;
    logic [DATA_W-1:0] p2data = '0;
    logic [5:0]        screen;
    logic [3:0]        level;
    logic [3:0]        pos;
    logic              running;
    logic              p1_win;
    logic              p2_win;
    logic              step;

    tug_engine #(
        .DATA_W(DATA_W), .NPOS(NPOS), .STEP_CYCLES(STEP_CYCLES),
        .DEADBAND(DEADBAND), .HYST(HYST)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start),
        .p1data(p1data), .p2data(p2data), .screen(screen), .level(level),
        .pos(pos), .running(running), .p1_win(p1_win), .p2_win(p2_win),
        .step(step)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard state
    logic [16:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    // abstract game model
    int m_level = 0;
    int m_pos = CENTER;
    bit m_mode = 1'b0;
    bit m_run = 1'b0;
    bit m_p1w = 1'b0;
    bit m_p2w = 1'b0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [16:0] exp_pkt();
        int scr;
        if (!m_mode) scr = m_level;
        else if (m_run || m_p1w || m_p2w) scr = 16 + m_pos;
        else scr = 31;
        return {6'(scr), 4'(m_level), 4'(m_pos), m_run, m_p1w, m_p2w};
    endfunction

    function automatic logic [16:0] got_pkt();
        return {screen, level, pos, running, p1_win, p2_win};
    endfunction

    function automatic void model_single(input int v);
        int b;
        b = v / (1 << SH);
        if (b > m_level && (v - b * (1 << SH)) >= HYST) m_level = b;
        else if (b < m_level && ((b + 1) * (1 << SH) - v) > HYST) m_level = b;
    endfunction

    function automatic void model_multi(input int a, input int b);
        if (!m_run) return;
        if (a - b > DEADBAND) m_pos++;
        else if (a - b < -DEADBAND) m_pos--;
        if (m_pos == NPOS - 1) begin m_run = 0; m_p1w = 1; end
        else if (m_pos == 0) begin m_run = 0; m_p2w = 1; end
    endfunction

    function automatic void model_restart();
        m_run = 1; m_p1w = 0; m_p2w = 0; m_pos = CENTER;
    endfunction

    // driver tasks (always called and returning at a falling edge)
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic single_step(input int v);
        p1data = DATA_W'(v);
        model_single(v);
        exp_q.push_back(exp_pkt());
        tick(STEP_CYCLES);
    endtask

    task automatic multi_step(input int a, input int b);
        p1data = DATA_W'(a);
        p2data = DATA_W'(b);
        model_multi(a, b);
        exp_q.push_back(exp_pkt());
        tick(STEP_CYCLES);
    endtask

    task automatic start_match(input int a, input int b);
        p1data = DATA_W'(a);
        p2data = DATA_W'(b);
        start = 1'b1;
        model_restart();
        tick(1);
        start = 1'b0;
        chk("after_start", int'(got_pkt()), int'(exp_pkt()));
    endtask

    // monitor: one expected snapshot per step strobe
    initial begin
        logic [16:0] e;
        forever begin
            @(negedge clk);
            if (step === 1'b1) begin
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_step", int'(got_pkt()), -1);
                end else begin
                    e = exp_q.pop_front();
                    chk("step_snapshot", int'(got_pkt()), int'(e));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: timeout, got no finish expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "timeout");
    end

    // stimulus
    initial begin
        int a, b, t;
        int single_tab[8] = '{'h250, 'h205, 'h1E0, 'hFFF, 'hEF0, 'hEEF, 'hF0F, 'hF10};

        p1data = 12'h250;
        tick(3);
        chk("reset_snapshot", int'(got_pkt()), int'(exp_pkt()));
        chk("reset_step", int'(step), 0);
        reset = 1'b0;

        // single mode: named hysteresis cases then random samples
        foreach (single_tab[i]) single_step(single_tab[i]);
        for (int i = 0; i < 16; i++) single_step($urandom_range(0, MAXV));

        // into multi mode
        mode = 1'b1;
        m_mode = 1'b1; m_run = 0; m_p1w = 0; m_p2w = 0; m_pos = CENTER;
        tick(2);
        chk("multi_idle", int'(got_pkt()), int'(exp_pkt()));

        // player 1 wins, then the rope stays frozen
        start_match('h800, 'h100);
        while (m_run) multi_step('h800, 'h100);
        tick(3 * STEP_CYCLES);
        chk("p1_win_frozen", int'(got_pkt()), int'(exp_pkt()));
        chk("p1_win_screen", int'(screen), 30);

        // dead band edge, then random tugging
        start_match('h840, 'h800);
        multi_step('h840, 'h800);
        multi_step('h840, 'h800);
        multi_step('h840, 'h7FF);
        chk("deadband_pos", int'(pos), 8);
        for (int i = 0; i < 14; i++) begin
            if (m_run) begin
                a = $urandom_range(0, MAXV);
                if ($urandom_range(0, 2) == 0) b = $urandom_range(0, MAXV);
                else begin
                    t = a + $urandom_range(0, 2 * DEADBAND + 4) - (DEADBAND + 2);
                    b = (t < 0) ? 0 : (t > MAXV) ? MAXV : t;
                end
                multi_step(a, b);
            end
        end

        // player 2 wins, then restart
        start_match('h100, 'hF00);
        while (m_run) multi_step('h100, 'hF00);
        chk("p2_win_screen", int'(screen), 16);
        start_match('h100, 'hF00);
        multi_step('h100, 'hF00);
        chk("p2_restart_move", int'(pos), CENTER - 1);

        // start coinciding with a step: restart, no move
        start_match('h900, 'h100);
        multi_step('h900, 'h100);
        tick(STEP_CYCLES - 1);
        chk("collision_step_strobe", int'(step), 1);
        start = 1'b1;
        model_restart();
        exp_q.push_back(exp_pkt());
        tick(1);
        start = 1'b0;
        multi_step('h900, 'h100);

        // leave multi mode mid-match
        mode = 1'b0;
        m_mode = 1'b0; m_run = 0; m_p1w = 0; m_p2w = 0; m_pos = CENTER;
        #1;
        chk("toggle_screen_level", int'(screen), m_level);
        tick(1);
        chk("toggle_idle", int'(got_pkt()), int'(exp_pkt()));
        for (int i = 0; i < 4; i++) single_step($urandom_range(0, MAXV));

        // back to multi, asynchronous reset mid-match
        mode = 1'b1;
        m_mode = 1'b1;
        tick(2);
        start_match('h900, 'h100);
        multi_step('h900, 'h100);
        tick(2);
        reset = 1'b1;
        #1;
        m_level = 0; m_pos = CENTER; m_run = 0; m_p1w = 0; m_p2w = 0;
        chk("async_reset", int'(got_pkt()), int'(exp_pkt()));
        chk("async_reset_screen", int'(screen), 31);
        tick(2);
        reset = 1'b0;
        tick(3 * STEP_CYCLES);
        chk("post_reset_idle", int'(got_pkt()), int'(exp_pkt()));
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
